// File: rtl/mano_ureg_pkg.sv
// Shared operation encodings and priority order for the mano_ureg register.
package mano_ureg_pkg;

  localparam int NUM_OPS = 6;

  typedef enum logic [NUM_OPS-1:0] {
    OP_NONE = 6'b000000,
    OP_CLR  = 6'b000001,
    OP_INC  = 6'b000010,
    OP_LD   = 6'b000100,
    OP_DEC  = 6'b001000,
    OP_SHL  = 6'b010000,
    OP_SHR  = 6'b100000
  } op_e;

  // Highest priority first; index 0 wins when several requests are asserted.
  localparam op_e PRIO_ORDER [NUM_OPS] = '{OP_CLR, OP_INC, OP_LD, OP_DEC, OP_SHL, OP_SHR};

endpackage

// File: rtl/mano_ureg_prio.sv
// Combinational priority encoder: six request lines to a one-hot operation select.
module mano_ureg_prio
  import mano_ureg_pkg::*;
(
  input  logic clr,
  input  logic inc,
  input  logic ld,
  input  logic dec,
  input  logic shl,
  input  logic shr,
  output op_e  sel
);

  logic [NUM_OPS-1:0] reqv;

  assign reqv = ({NUM_OPS{clr}} & OP_CLR) | ({NUM_OPS{inc}} & OP_INC) |
                ({NUM_OPS{ld}}  & OP_LD)  | ({NUM_OPS{dec}} & OP_DEC) |
                ({NUM_OPS{shl}} & OP_SHL) | ({NUM_OPS{shr}} & OP_SHR);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    sel = OP_NONE;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if ((reqv & PRIO_ORDER[i]) != '0) sel = PRIO_ORDER[i];
    end
  end

endmodule

// File: rtl/mano_ureg.sv
// Mano-style universal register: clear, increment, load, decrement and serial shifts
// with carry/borrow flag, sticky overflow and a combinational zero flag.
module mano_ureg
  import mano_ureg_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               SAT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             ld,
  input  logic             dec,
  input  logic             shl,
  input  logic             shr,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             cy,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  op_e              sel;
  logic [WIDTH-1:0] q_nxt;
  logic             cy_nxt;
  logic             ovf_nxt;
  logic             q_max;
  logic             q_min;

  mano_ureg_prio u_prio (
    .clr (clr),
    .inc (inc),
    .ld  (ld),
    .dec (dec),
    .shl (shl),
    .shr (shr),
    .sel (sel)
  );

  assign q_max = &q;
  assign q_min = (q == '0);
  assign zero  = q_min;

  // Boundary inc/dec flag overflow; saturation simply leaves q where it is.
  always_comb begin
    q_nxt   = q;
    cy_nxt  = cy;
    ovf_nxt = ovf;
    case (sel)
      OP_CLR: begin
        q_nxt   = RST_VAL;
        cy_nxt  = 1'b0;
        ovf_nxt = 1'b0;
      end
      OP_INC: begin
        if (q_max) begin
          q_nxt   = (SAT != 0) ? q : '0;
          cy_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end else begin
          q_nxt  = q + ONE;
          cy_nxt = 1'b0;
        end
      end
      OP_LD: begin
        q_nxt  = d;
        cy_nxt = 1'b0;
      end
      OP_DEC: begin
        if (q_min) begin
          q_nxt   = (SAT != 0) ? q : '1;
          cy_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end else begin
          q_nxt  = q - ONE;
          cy_nxt = 1'b0;
        end
      end
      OP_SHL: begin
        q_nxt  = {q[WIDTH-2:0], sin};
        cy_nxt = q[WIDTH-1];
      end
      OP_SHR: begin
        q_nxt  = {sin, q[WIDTH-1:1]};
        cy_nxt = q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= q_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cy <= 1'b0;
    else     cy <= cy_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= ovf_nxt;
  end

endmodule

// File: tb/tb_mano_ureg.sv
// Self-checking bench for mano_ureg: wrap/RST_VAL=0, saturate/RST_VAL=0x07, and 16-bit instances.
module tb_mano_ureg;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] CLR  = 6'b100000;
  localparam logic [5:0] INC  = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] DEC  = 6'b000100;
  localparam logic [5:0] SHL  = 6'b000010;
  localparam logic [5:0] SHR  = 6'b000001;

  logic        clk;
  logic        rst;
  logic        clr, inc, ld, dec, shl, shr, sin;
  logic [15:0] d;

  logic [7:0]  qa, qb;
  logic [15:0] qc;
  logic        cya, ovfa, zeroa;
  logic        cyb, ovfb, zerob;
  logic        cyc, ovfc, zeroc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] ops;
    logic       s;
    logic [7:0] dv;
    logic [7:0] eq;
    logic       ecy;
    logic       eovf;
    logic       ez;
  } vec_t;

  vec_t vecs [17];

  mano_ureg #(.WIDTH(8), .RST_VAL(8'h00), .SAT(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .ld(ld), .dec(dec),
    .shl(shl), .shr(shr), .sin(sin), .d(d[7:0]),
    .q(qa), .cy(cya), .ovf(ovfa), .zero(zeroa)
  );

  mano_ureg #(.WIDTH(8), .RST_VAL(8'h07), .SAT(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .ld(ld), .dec(dec),
    .shl(shl), .shr(shr), .sin(sin), .d(d[7:0]),
    .q(qb), .cy(cyb), .ovf(ovfb), .zero(zerob)
  );

  mano_ureg #(.WIDTH(16), .RST_VAL(16'h0000), .SAT(0)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .ld(ld), .dec(dec),
    .shl(shl), .shr(shr), .sin(sin), .d(d),
    .q(qc), .cy(cyc), .ovf(ovfc), .zero(zeroc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one set of requests across a single rising edge, then drop them.
  task automatic applyStimulus(input logic [5:0] ops, input logic s, input logic [15:0] dv);
    {clr, inc, ld, dec, shl, shr} = ops;
    sin = s;
    d   = dv;
    @(posedge clk);
    #1;
    {clr, inc, ld, dec, shl, shr} = NONE;
    sin = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{LD,        1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{INC,       1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{INC,       1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{NONE,      1'b1, 8'hAA, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{CLR,       1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{LD,        1'b0, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{SHL,       1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{SHR,       1'b1, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{SHR,       1'b0, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{DEC,       1'b0, 8'h00, 8'h3F, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{INC|DEC,   1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{LD,        1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{DEC,       1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{LD|DEC,    1'b0, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{DEC|SHL,   1'b0, 8'h00, 8'h0F, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{SHL|SHR,   1'b1, 8'h00, 8'h1F, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{CLR|INC|LD|DEC, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 1'b1};

    {clr, inc, ld, dec, shl, shr, sin} = '0;
    d   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_qa", qa, 8'h00);
    checkOutput("reset_qb", qb, 8'h07);
    checkOutput("reset_flags_a", {cya, ovfa, zeroa}, 3'b001);
    rst = 1'b0;

    // Mid-cycle asynchronous reset with q=0x5A.
    applyStimulus(LD, 1'b0, 16'h005A);
    checkOutput("case1_load", qa, 8'h5A);
    #3 rst = 1'b1;
    #1;
    checkOutput("case1_async_q", qa, 8'h00);
    checkOutput("case1_async_flags", {cya, ovfa, zeroa}, 3'b001);
    #2 rst = 1'b0;

    // Requests are ignored while reset is held across an edge.
    rst = 1'b1;
    applyStimulus(INC, 1'b0, 16'h0000);
    checkOutput("rst_ignores_inc", qa, 8'h00);
    rst = 1'b0;
    applyStimulus(INC, 1'b0, 16'h0000);
    checkOutput("first_edge_after_rst", qa, 8'h01);
    applyStimulus(CLR, 1'b0, 16'h0000);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].ops, vecs[i].s, {8'h00, vecs[i].dv});
      checkOutput($sformatf("vec%0d_q", i), qa, vecs[i].eq);
      checkOutput($sformatf("vec%0d_flags", i), {cya, ovfa, zeroa},
                  {vecs[i].ecy, vecs[i].eovf, vecs[i].ez});
    end

    // Saturating decrement at zero, sticky ovf through load, cleared by clr.
    applyStimulus(CLR, 1'b0, 16'h0000);
    applyStimulus(LD, 1'b0, 16'h0000);
    applyStimulus(DEC, 1'b0, 16'h0000);
    checkOutput("case3_dec_sat", {qb, cyb, ovfb}, {8'h00, 1'b1, 1'b1});
    applyStimulus(LD, 1'b0, 16'h0010);
    checkOutput("case3_ld_keeps_ovf", {qb, cyb, ovfb}, {8'h10, 1'b0, 1'b1});
    applyStimulus(CLR, 1'b0, 16'h0000);
    checkOutput("case3_clr", {qb, cyb, ovfb}, {8'h07, 1'b0, 1'b0});

    applyStimulus(LD, 1'b0, 16'h00FF);
    applyStimulus(INC, 1'b0, 16'h0000);
    checkOutput("sat_inc_hold", {qb, cyb, ovfb}, {8'hFF, 1'b1, 1'b1});

    // Priority: clr beats everything, then inc beats ld and dec.
    applyStimulus(LD, 1'b0, 16'h0033);
    checkOutput("case5_setup", qb, 8'h33);
    applyStimulus(CLR | INC | LD | DEC, 1'b0, 16'h0099);
    checkOutput("case5_clr_wins", qb, 8'h07);
    applyStimulus(INC | LD | DEC, 1'b0, 16'h0099);
    checkOutput("case5_inc_wins", qb, 8'h08);

    // 16-bit wrap on decrement and increment.
    applyStimulus(CLR, 1'b0, 16'h0000);
    applyStimulus(LD, 1'b0, 16'h0000);
    applyStimulus(DEC, 1'b0, 16'h0000);
    checkOutput("case6_dec_wrap", {qc, cyc, ovfc, zeroc}, {16'hFFFF, 1'b1, 1'b1, 1'b0});
    applyStimulus(INC, 1'b0, 16'h0000);
    checkOutput("w16_inc_wrap", {qc, cyc, ovfc, zeroc}, {16'h0000, 1'b1, 1'b1, 1'b1});
    applyStimulus(LD, 1'b0, 16'h8001);
    applyStimulus(SHR, 1'b1, 16'h0000);
    checkOutput("w16_shr", {qc, cyc}, {16'hC000, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
